// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
// Width macros fall back to RV32 values when common/defines.svh is not included.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0013
`endif

package imem_arb_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    localparam int PORT_FETCH     = 0;
    localparam int PORT_DATA      = 1;
    localparam int CONFLICT_CNT_W = 32;

    localparam logic [`INSTR_WIDTH-1:0] NOP_WORD = `NOP_INSTRUCTION;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/imem_rr_arb2.sv
// Two-way arbiter; round-robin tie break under IMEM_ARB_ROUND_ROBIN_EN,
// otherwise fixed priority with the fetch port winning ties.
module imem_rr_arb2
    import imem_arb_pkg::*;
(
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic [1:0] elig,
    output logic [1:0] grant
);

`ifdef IMEM_ARB_ROUND_ROBIN_EN
    // Resetting to the data port makes the fetch port win the first tie.
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (&elig) begin
            grant = (last_grant_q == 1'(PORT_DATA)) ? 2'b01 : 2'b10;
        end else begin
            grant = elig;
        end
        if (|grant) begin
            last_grant_d = grant[PORT_DATA];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'(PORT_DATA);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        grant = (&elig) ? 2'b01 : elig;
    end
`endif

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the combinational instruction-memory read port between fetch (port 0)
// and data reads (port 1). Tie policy selected by IMEM_ARB_ROUND_ROBIN_EN.
module imem_port_arbiter
    import imem_arb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [`DATA_WIDTH-1:0]    req_addr0,
    input  logic [`DATA_WIDTH-1:0]    req_addr1,
    output logic [1:0]                resp_valid,
    input  logic [1:0]                resp_ready,
    output logic [`INSTR_WIDTH-1:0]   resp_data0,
    output logic [`INSTR_WIDTH-1:0]   resp_data1,
    output logic [1:0]                resp_err,
    input  logic                      flush,
    output logic [`DATA_WIDTH-1:0]    mem_addr,
    input  logic [`INSTR_WIDTH-1:0]   mem_rdata,
    output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);

    slot_state_e                state_q [2];
    slot_state_e                state_d [2];
    logic [`INSTR_WIDTH-1:0]    data_q  [2];
    logic [`INSTR_WIDTH-1:0]    data_d  [2];
    logic [1:0]                 err_q;
    logic [1:0]                 err_d;
    logic [CONFLICT_CNT_W-1:0]  cnt_q;
    logic [CONFLICT_CNT_W-1:0]  cnt_d;
    logic [1:0]                 elig;
    logic [1:0]                 grant;
    logic [1:0]                 addr_lsb [2];

    imem_rr_arb2 u_arb (
`ifdef IMEM_ARB_ROUND_ROBIN_EN
        .clk   (clk),
        .rst_n (rst_n),
`endif
        .elig  (elig),
        .grant (grant)
    );

    always_comb begin
        resp_valid[PORT_FETCH] = (state_q[PORT_FETCH] == SLOT_FULL);
        resp_valid[PORT_DATA]  = (state_q[PORT_DATA] == SLOT_FULL);

        // A slot can take a new word when empty or being drained this cycle.
        elig[PORT_FETCH] = req_valid[PORT_FETCH] & (~resp_valid[PORT_FETCH] | resp_ready[PORT_FETCH]) & ~flush;
        elig[PORT_DATA]  = req_valid[PORT_DATA] & (~resp_valid[PORT_DATA] | resp_ready[PORT_DATA]);

        req_ready = grant;
        mem_addr  = grant[PORT_DATA] ? req_addr1 : req_addr0;

        addr_lsb[PORT_FETCH] = req_addr0[1:0];
        addr_lsb[PORT_DATA]  = req_addr1[1:0];

        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            data_d[i]  = data_q[i];
            err_d[i]   = err_q[i];
            if (grant[i]) begin
                state_d[i] = SLOT_FULL;
                if (is_word_aligned(addr_lsb[i])) begin
                    data_d[i] = mem_rdata;
                    err_d[i]  = 1'b0;
                end else begin
                    data_d[i] = NOP_WORD;
                    err_d[i]  = 1'b1;
                end
            end else if (resp_ready[i] || (i == PORT_FETCH && flush)) begin
                state_d[i] = SLOT_EMPTY;
            end
        end

        cnt_d = cnt_q;
        if ((&elig) && (cnt_q != {CONFLICT_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= SLOT_EMPTY;
                data_q[i]  <= NOP_WORD;
            end
            err_q <= 2'b00;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                data_q[i]  <= data_d[i];
            end
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign resp_data0   = data_q[PORT_FETCH];
    assign resp_data1   = data_q[PORT_DATA];
    assign resp_err     = err_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized bench for imem_port_arbiter against a transaction-level model;
// the model's tie rule follows IMEM_ARB_ROUND_ROBIN_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0013
`endif

module tb_imem_port_arbiter;

    localparam logic [31:0] NOP = `NOP_INSTRUCTION;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [1:0]              req_valid = '0;
    logic [1:0]              req_ready;
    logic [`DATA_WIDTH-1:0]  req_addr0 = '0;
    logic [`DATA_WIDTH-1:0]  req_addr1 = '0;
    logic [1:0]              resp_valid;
    logic [1:0]              resp_ready = '0;
    logic [`INSTR_WIDTH-1:0] resp_data0;
    logic [`INSTR_WIDTH-1:0] resp_data1;
    logic [1:0]              resp_err;
    logic                    flush = 1'b0;
    logic [`DATA_WIDTH-1:0]  mem_addr;
    logic [`INSTR_WIDTH-1:0] mem_rdata;
    logic [31:0]             conflict_cnt;

    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[9:2]];

    imem_port_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr0    (req_addr0),
        .req_addr1    (req_addr1),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data0   (resp_data0),
        .resp_data1   (resp_data1),
        .resp_err     (resp_err),
        .flush        (flush),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per-port slot contents plus who won the last grant.
    logic        m_valid [2];
    logic [31:0] m_data  [2];
    logic        m_err   [2];
    logic [31:0] m_cnt;
    int          m_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = NOP;
            m_err[i]   = 1'b0;
        end
        m_cnt  = 0;
        m_last = 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'(2'b00));
        check({tag, "_resp_data0"}, 64'(resp_data0), 64'(NOP));
        check({tag, "_resp_data1"}, 64'(resp_data1), 64'(NOP));
        check({tag, "_resp_err"}, 64'(resp_err), 64'(2'b00));
        check({tag, "_conflict_cnt"}, 64'(conflict_cnt), 64'(0));
        check({tag, "_req_ready"}, 64'(req_ready), 64'(2'b00));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        resp_ready = '0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("reset");
    endtask

    // One clock cycle: drive, check the combinational grant, clock, check the slots.
    task automatic step(input logic [1:0] rv, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [1:0] rr, input logic fl, output logic [1:0] got_ready);
        int          winner;
        logic [1:0]  exp_grant;
        logic [31:0] addr;
        bit          e0, e1;
        @(negedge clk);
        req_valid  = rv;
        req_addr0  = a0;
        req_addr1  = a1;
        resp_ready = rr;
        flush      = fl;
        #1;
        e0 = rv[0] && (!m_valid[0] || rr[0]) && !fl;
        e1 = rv[1] && (!m_valid[1] || rr[1]);
        winner = -1;
        if (e0 && e1) begin
`ifdef IMEM_ARB_ROUND_ROBIN_EN
            winner = 1 - m_last;
`else
            winner = 0;
`endif
        end else if (e0) begin
            winner = 0;
        end else if (e1) begin
            winner = 1;
        end
        exp_grant = (winner < 0) ? 2'b00 : 2'(1 << winner);
        got_ready = req_ready;
        check("req_ready", 64'(req_ready), 64'(exp_grant));
        check("mem_addr", 64'(mem_addr), 64'((winner == 1) ? a1 : a0));

        @(posedge clk);
        #1;
        if (e0 && e1 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        for (int i = 0; i < 2; i++) begin
            addr = (i == 0) ? a0 : a1;
            if (winner == i) begin
                m_valid[i] = 1'b1;
                if (addr % 4 == 0) begin
                    m_data[i] = mem[addr[9:2]];
                    m_err[i]  = 1'b0;
                end else begin
                    m_data[i] = NOP;
                    m_err[i]  = 1'b1;
                end
            end else if (rr[i] || (i == 0 && fl)) begin
                m_valid[i] = 1'b0;
            end
        end
        if (winner >= 0) m_last = winner;
        check("resp_valid", 64'(resp_valid), 64'({m_valid[1], m_valid[0]}));
        check("resp_data0", 64'(resp_data0), 64'(m_data[0]));
        check("resp_data1", 64'(resp_data1), 64'(m_data[1]));
        check("resp_err", 64'(resp_err), 64'({m_err[1], m_err[0]}));
        check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    endtask

    logic [1:0]  rdy;
    logic [1:0]  tie_exp [4];
    logic [31:0] held;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0010_0093;
        model_reset();

        // Fetch from address 0 right after reset.
        apply_reset();
        step(2'b01, 32'h0, 32'h0, 2'b00, 1'b0, rdy);
        check("first_ready", 64'(rdy), 64'(2'b01));
        check("first_data", 64'(resp_data0), 64'(32'h0010_0093));
        check("first_valid", 64'(resp_valid[0]), 64'(1'b1));

        // Four contended cycles from reset.
        apply_reset();
`ifdef IMEM_ARB_ROUND_ROBIN_EN
        tie_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        tie_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        for (int k = 0; k < 4; k++) begin
            step(2'b11, 32'h4 * (k + 1), 32'h40 + 32'h4 * k, 2'b11, 1'b0, rdy);
            check("tie_grant", 64'(rdy), 64'(tie_exp[k]));
        end
        check("tie_cnt", 64'(conflict_cnt), 64'(4));

        // Port 1 slot held while port 1 asks again.
        apply_reset();
        step(2'b10, 32'h0, 32'h10, 2'b00, 1'b0, rdy);
        held = mem[4];
        step(2'b11, 32'h8, 32'h20, 2'b00, 1'b0, rdy);
        check("hold_ready", 64'(rdy), 64'(2'b01));
        check("hold_data1", 64'(resp_data1), 64'(held));

        // Misaligned fetch.
        apply_reset();
        step(2'b01, 32'h6, 32'h0, 2'b00, 1'b0, rdy);
        check("misalign_err", 64'(resp_err[0]), 64'(1'b1));
        check("misalign_data", 64'(resp_data0), 64'(NOP));

        // Flush with port 0 full and not drained.
        apply_reset();
        step(2'b01, 32'h8, 32'h0, 2'b00, 1'b0, rdy);
        step(2'b11, 32'hC, 32'h20, 2'b00, 1'b1, rdy);
        check("flush_ready", 64'(rdy), 64'(2'b10));
        check("flush_valid", 64'(resp_valid), 64'(2'b10));
        check("flush_data1", 64'(resp_data1), 64'(mem[8]));

        // Asynchronous reset with both slots full.
        step(2'b01, 32'h14, 32'h0, 2'b00, 1'b0, rdy);
        check("prereset_full", 64'(resp_valid), 64'(2'b11));
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] ra0, ra1;
            ra0 = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 1023)) : 32'($urandom_range(0, 255) * 4);
            ra1 = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 1023)) : 32'($urandom_range(0, 255) * 4);
            step(2'($urandom_range(0, 3)), ra0, ra1, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Two-requester controller sharing the single combinational read port of the instruction memory between the core fetch stage (port 0) and a data-side read path (port 1, loads from code space and debug reads). Each cycle it grants at most one requester, drives the memory address, and captures the returned word into a per-port registered response slot with valid/ready handshaking. It sits between the fetch/LSU request logic and the instruction memory, and supplies the fetch-redirect flush hook.

## Interface
- No module parameters; widths come from `` `DATA_WIDTH``, `` `INSTR_WIDTH`` and `` `NOP_INSTRUCTION`` in `common/defines.svh`.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst_n`: input, 1 bit. Asynchronous active-low reset.
- `req_valid[1:0]`: input, 2 bits. Per-port request valid.
- `req_ready[1:0]`: output, 2 bits. Per-port request accepted this cycle.
- `req_addr0`, `req_addr1`: input, `DATA_WIDTH` bits each. Byte address per port.
- `resp_valid[1:0]`: output, 2 bits. Per-port response slot full.
- `resp_ready[1:0]`: input, 2 bits. Per-port response consumed.
- `resp_data0`, `resp_data1`: output, `INSTR_WIDTH` bits each. Registered instruction word.
- `resp_err[1:0]`: output, 2 bits. Response came from a misaligned address.
- `flush`: input, 1 bit. Fetch redirect; kills port 0 only.
- `mem_addr`: output, `DATA_WIDTH` bits. Address to the instruction memory.
- `mem_rdata`: input, `INSTR_WIDTH` bits. Combinational memory read data.
- `conflict_cnt`: output, 32 bits. Saturating count of contention cycles.

## Operation
- Eligibility: `elig_i = req_valid[i] & (!resp_valid[i] | resp_ready[i])`. Port 0 is additionally ineligible in any cycle where `flush` is 1.
- Grant: at most one port per cycle (one-hot or none). With a single eligible port, that port wins. With both eligible, the arbitration policy applies (see Configuration).
- `req_ready[i] = grant[i]`, combinational in the same cycle. A request is accepted when `req_valid[i] & req_ready[i]`.
- `mem_addr` equals the granted port's address. With no grant it holds port 0's address.
- Capture on accept:
  - `resp_data_i <= mem_rdata` and `resp_err[i] <= 0` when `addr[1:0] == 0`.
  - Otherwise `resp_data_i <= NOP` and `resp_err[i] <= 1`. The grant slot is still consumed.
- Each response slot is a two-state FSM, EMPTY or FULL:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on `resp_ready` without a new accept.
  - FULL -> FULL on `resp_ready` with a same-cycle accept (back-to-back).
  - A slot never overwrites while FULL and not ready.
- `flush`: clears `resp_valid[0]` at the next edge, regardless of `resp_ready[0]`. It blocks port 0's grant that cycle and has no effect on port 1.
- `conflict_cnt`: increments by 1 in each cycle where both ports are eligible before masking by grant. It saturates at 0xFFFFFFFF.
- Out-of-range addresses are passed unchanged to memory; range handling belongs to the memory.

## Timing
- Reset values:
  - `resp_valid = 0`, `resp_err = 0`, `resp_data0 = resp_data1 = NOP`, `conflict_cnt = 0`.
  - `last_grant = 1`, so port 0 wins the first tie.
  - `req_ready` follows eligibility, which is 0 while `req_valid = 0`.
- Latency: accept at edge N gives `resp_valid` high in the cycle after edge N. Load-to-use is 1 cycle.
- Throughput: one accept per cycle in total. A single uncontended port with `resp_ready` held at 1 sustains 1 word per cycle.
- `req_ready` depends combinationally on `req_valid`, `resp_ready` and `flush`. `resp_valid` and `resp_data` depend only on registers, with no combinational path to them.
- Reset asserted mid-operation: slots empty immediately (asynchronously), and in-flight accepts are lost.
- Simultaneous `flush` and `resp_ready[0]`: the slot ends EMPTY.
- Simultaneous `flush` and a port 0 request: not accepted, because `req_ready[0] = 0`.

## Configuration
- `IMEM_ARB_ROUND_ROBIN_EN` defined: on a tie, the port not equal to `last_grant` wins. `last_grant` updates on every grant.
- `IMEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, port 0 (fetch) always wins ties. `last_grant` is removed, and the reset rule above still yields port 0 first.
- `conflict_cnt` behaves identically in both builds.

## Structure
- Package `imem_arb_pkg` holds:
  - `slot_state_e` {SLOT_EMPTY, SLOT_FULL}.
  - Port index constants `PORT_FETCH = 0` and `PORT_DATA = 1`.
  - `CONFLICT_CNT_W = 32`.
- One sub-module, `imem_rr_arb2`: 2-way arbiter with `last_grant` state, compiled as round-robin or fixed priority under the macro.

## Test plan
- After reset, port 0 requests 0x0 with the memory preloaded to 0x00100093 -> `req_ready[0] = 1`, next cycle `resp_valid[0] = 1`, `resp_data0 = 0x00100093`, `resp_err[0] = 0`.
- Both ports request every cycle for 4 cycles with `resp_ready = 11` -> round-robin grants 0,1,0,1 (fixed priority: 0,0,0,0), and `conflict_cnt = 4`.
- Port 1 response held (`resp_ready[1] = 0`) while a new port 1 request arrives -> `req_ready[1] = 0`, `resp_data1` unchanged, and port 0 is granted meanwhile.
- Port 0 requests 0x6 -> `resp_err[0] = 1`, `resp_data0 = NOP`.
- Port 0 slot FULL with `flush = 1`, `resp_ready[0] = 0` and port 0 requesting -> next cycle `resp_valid[0] = 0`, no port 0 accept, and port 1 is unaffected.
- `rst_n` driven low mid-stream with both slots FULL -> all outputs return to reset values asynchronously before the next clock edge.
